ahfp_fixed_2_float_pipe: RTL and testbench

- Downstream partner of the float-to-fixed converter: takes signed 32-bit fixed-point results from the fixed-point datapath and returns IEEE-754 single-precision floats.
- Three-stage pipeline: sign/abs, then leading-zero count, then normalise/round/pack.
- valid/ready handshake on both sides; full throughput of 1 sample per cycle; stalls on back-pressure.

---
 rtl/ahfp_pkg.sv | 20 ++
 rtl/ahfp_lzc32.sv | 25 ++
 rtl/ahfp_fixed_2_float_pipe.sv | 147 ++++++++++++++
 tb/tb_ahfp_fixed_2_float_pipe.sv | 346 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ahfp_pkg.sv
// Shared constants and field layout for the fixed-to-float converter.
//
// Contents:
//   FLT_BIAS, FLT_EXP_W, FLT_MAN_W : IEEE-754 single-precision layout
//   FIX_W                          : width of the fixed-point input word
//   flt_t                          : packed {sign, exp, mant} float word
package ahfp_pkg;

    localparam int FLT_BIAS  = 127;
    localparam int FLT_EXP_W = 8;
    localparam int FLT_MAN_W = 23;
    localparam int FIX_W     = 32;

    typedef struct packed {
        logic                 sign;
        logic [FLT_EXP_W-1:0] exp;
        logic [FLT_MAN_W-1:0] mant;
    } flt_t;

endpackage

// File: rtl/ahfp_lzc32.sv
// Combinational 32-bit leading-zero counter.
//
// Ports:
//   value : word to inspect
//   count : number of leading zeros, 0..32 (32 when value is zero)
//   zero  : value == 0
module ahfp_lzc32 (
    input  logic [31:0] value,
    output logic [5:0]  count,
    output logic        zero
);

    // Scan from LSB upward so the highest set bit has the final say.
    always_comb begin
        count = 6'd32;
        for (int i = 0; i < 32; i++) begin
            if (value[i]) begin
                count = 6'(31 - i);
            end
        end
    end

    assign zero = (value == 32'h0);

endmodule

// File: rtl/ahfp_fixed_2_float_pipe.sv
// Signed fixed-point (FRAC_BITS fraction bits) to IEEE-754 single-precision
// converter, three pipeline stages with valid/ready flow control:
//   stage _p0 : sign and magnitude
//   stage _p1 : leading-zero count
//   stage _p2 : normalise, round, pack (drives the outputs)
//
// Ports:
//   clk       : clock, rising edge
//   rst       : asynchronous active-high reset
//   in_valid  : in_data is valid
//   in_ready  : converter accepts in_data this cycle
//   in_data   : two's-complement input, value = in_data / 2^FRAC_BITS
//   out_valid : out_data is valid
//   out_ready : consumer accepts out_data this cycle
//   out_data  : single-precision result
//
// Build option: define AHFP_FIXED2FLOAT_RNE_EN to round to nearest even;
// otherwise the discarded bits are truncated (round toward zero).
module ahfp_fixed_2_float_pipe
    import ahfp_pkg::*;
#(
    parameter int FRAC_BITS = 29
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data
);

    localparam int EXP_BASE = FLT_BIAS + FIX_W - 1 - FRAC_BITS;
    localparam int EM_W     = FLT_EXP_W + FLT_MAN_W;

`ifdef AHFP_FIXED2FLOAT_RNE_EN
    // Adding one to the joint {exp, mant} field lets a mantissa carry-out
    // bump the exponent for free.
    function automatic logic [EM_W-1:0] round_rne(
        input logic [EM_W-1:0] em,
        input logic            guard,
        input logic            sticky
    );
        if (guard && (sticky || em[0])) begin
            return em + EM_W'(1);
        end
        return em;
    endfunction
`endif

    function automatic flt_t pack_float(
        input logic             sign,
        input logic [FIX_W-1:0] mag,
        input logic [5:0]       lzc,
        input logic             zero
    );
        logic [FIX_W-1:0] norm;
        logic [EM_W-1:0]  em;
        flt_t             f;
        norm = mag << lzc;
        // norm[31] is the hidden one; the mantissa is the next 23 bits.
        em   = {FLT_EXP_W'(EXP_BASE - int'(lzc)), FLT_MAN_W'(norm >> 8)};
`ifdef AHFP_FIXED2FLOAT_RNE_EN
        em   = round_rne(em, norm[7], |norm[6:0]);
`endif
        if (zero) begin
            f = '0;
        end else begin
            f = {sign, em};
        end
        return f;
    endfunction

    logic vld_p0, vld_p1, vld_p2;
    logic ready_p1, ready_p2;

    assign ready_p2 = !vld_p2 || out_ready;
    assign ready_p1 = !vld_p1 || ready_p2;
    assign in_ready = !vld_p0 || ready_p1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_p0 <= 1'b0;
            vld_p1 <= 1'b0;
            vld_p2 <= 1'b0;
        end else begin
            if (in_ready) vld_p0 <= in_valid;
            if (ready_p1) vld_p1 <= vld_p0;
            if (ready_p2) vld_p2 <= vld_p1;
        end
    end

    // ---- stage _p0: sign / magnitude ----
    logic signed [FIX_W-1:0] din;
    logic                    sign_p0;
    logic [FIX_W-1:0]        mag_p0;

    assign din = in_data;

    // Negating the most negative word wraps back to 2^31, which read as
    // unsigned is exactly the magnitude required.
    always_ff @(posedge clk) begin
        if (in_valid && in_ready) begin
            sign_p0 <= din[FIX_W-1];
            mag_p0  <= din[FIX_W-1] ? $unsigned(-din) : $unsigned(din);
        end
    end

    // ---- stage _p1: leading-zero count ----
    logic [5:0]       lzc_d;
    logic             zero_d;
    logic             sign_p1;
    logic [FIX_W-1:0] mag_p1;
    logic [5:0]       lzc_p1;
    logic             zero_p1;

    ahfp_lzc32 u_lzc (
        .value (mag_p0),
        .count (lzc_d),
        .zero  (zero_d)
    );

    always_ff @(posedge clk) begin
        if (vld_p0 && ready_p1) begin
            sign_p1 <= sign_p0;
            mag_p1  <= mag_p0;
            lzc_p1  <= lzc_d;
            zero_p1 <= zero_d;
        end
    end

    // ---- stage _p2: normalise / round / pack ----
    flt_t res_p2;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            res_p2 <= '0;
        end else if (vld_p1 && ready_p2) begin
            res_p2 <= pack_float(sign_p1, mag_p1, lzc_p1, zero_p1);
        end
    end

    assign out_valid = vld_p2;
    assign out_data  = res_p2;

endmodule

// File: tb/tb_ahfp_fixed_2_float_pipe.sv
// Self-checking bench for ahfp_fixed_2_float_pipe (FRAC_BITS = 29).
// Expected values follow the build: define AHFP_FIXED2FLOAT_RNE_EN for both
// the design and this bench to check the round-to-nearest-even variant.
module tb_ahfp_fixed_2_float_pipe;

`ifdef AHFP_FIXED2FLOAT_RNE_EN
    localparam bit RNE = 1'b1;
`else
    localparam bit RNE = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;

    int checks = 0;
    int errors = 0;

    logic [31:0] out_q[$];
    logic [31:0] stim[$];

    ahfp_fixed_2_float_pipe #(.FRAC_BITS(29)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
    );

    always #5 clk = ~clk;

    // Record every completed output transfer (inputs are stable at negedge).
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) out_q.push_back(out_data);
    end

    // Reference: exact value as a double, then cut the double's 52-bit
    // mantissa down to 23 bits.
    function automatic logic [31:0] ref_conv(input logic [31:0] x);
        real         r;
        logic [63:0] b;
        int          se;
        logic [30:0] em;
        if (x == 32'h0) return 32'h0;
        r  = real'(int'($signed(x))) / 536870912.0;
        b  = $realtobits(r);
        se = int'(b[62:52]) - 1023 + 127;
        em = {se[7:0], b[51:29]};
        if (RNE && b[28] && ((|b[27:0]) || b[29])) em = em + 31'd1;
        return {b[63], em};
    endfunction

    // Push every word in stim with out_ready=1 and wait for as many outputs.
    task automatic drive_stim;
        int idx = 0;
        int cyc = 0;
        int n   = stim.size();
        out_q.delete();
        out_ready = 1'b1;
        while ((idx < n || out_q.size() < n) && cyc < 200) begin
            in_valid = (idx < n);
            in_data  = (idx < n) ? stim[idx] : 32'h0;
            @(negedge clk);
            if (in_valid && in_ready) idx++;
            @(posedge clk); #1;
            cyc++;
        end
        in_valid = 1'b0;
    endtask

    task automatic test_reset;
        #1;
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_out_valid: got %b expected 0", out_valid);
        end
        checks++;
        if (out_data !== 32'h0) begin
            errors++;
            $display("FAIL reset_out_data: got %h expected 00000000", out_data);
        end
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_in_ready: got %b expected 1", in_ready);
        end
    endtask

    task automatic test_basic;
        logic [31:0] vin[4]  = '{32'h20000000, 32'h00000000, 32'h04000000, 32'hE0000000};
        logic [31:0] vexp[4] = '{32'h3F800000, 32'h00000000, 32'h3E000000, 32'hBF800000};
        out_ready = 1'b1;
        for (int i = 0; i < 7; i++) begin
            in_valid = (i < 4);
            in_data  = (i < 4) ? vin[i] : 32'h0;
            @(negedge clk);
            if (i < 4) begin
                checks++;
                if (in_ready !== 1'b1) begin
                    errors++;
                    $display("FAIL basic_in_ready[%0d]: got %b expected 1", i, in_ready);
                end
            end
            checks++;
            if (out_valid !== (i >= 3)) begin
                errors++;
                $display("FAIL basic_out_valid[cycle %0d]: got %b expected %b", i, out_valid, (i >= 3));
            end
            if (i >= 3) begin
                checks++;
                if (out_data !== vexp[i-3]) begin
                    errors++;
                    $display("FAIL basic_data[%0d]: got %h expected %h", i - 3, out_data, vexp[i-3]);
                end
            end
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
    endtask

    task automatic test_extremes;
        logic [31:0] vin[3] = '{32'h80000000, 32'h00000001, 32'h7FFFFFFF};
        logic [31:0] vexp[3];
        vexp = '{32'hC0800000, 32'h31000000, RNE ? 32'h40800000 : 32'h407FFFFF};
        stim.delete();
        foreach (vin[i]) stim.push_back(vin[i]);
        drive_stim();
        checks++;
        if (out_q.size() != 3) begin
            errors++;
            $display("FAIL extremes_count: got %0d expected 3", out_q.size());
        end
        for (int i = 0; i < 3 && i < out_q.size(); i++) begin
            checks++;
            if (out_q[i] !== vexp[i]) begin
                errors++;
                $display("FAIL extremes[%h]: got %h expected %h", vin[i], out_q[i], vexp[i]);
            end
        end
    endtask

    task automatic test_rounding;
        // 01000001: tie with even mantissa, stays.
        // 01000003: tie with odd mantissa, rounds up under RNE.
        // 02000001: guard clear, sticky set, never rounds.
        // 01000180: all dropped bits clear.
        // 40000041: guard and sticky set with even mantissa, rounds up under RNE.
        logic [31:0] vin[5] = '{32'h01000001, 32'h01000003, 32'h02000001, 32'h01000180, 32'h40000041};
        logic [31:0] vexp[5];
        vexp = '{32'h3D000000, RNE ? 32'h3D000002 : 32'h3D000001, 32'h3D800000,
                 32'h3D0000C0, RNE ? 32'h40000001 : 32'h40000000};
        stim.delete();
        foreach (vin[i]) stim.push_back(vin[i]);
        drive_stim();
        checks++;
        if (out_q.size() != 5) begin
            errors++;
            $display("FAIL rounding_count: got %0d expected 5", out_q.size());
        end
        for (int i = 0; i < 5 && i < out_q.size(); i++) begin
            checks++;
            if (out_q[i] !== vexp[i]) begin
                errors++;
                $display("FAIL rounding[%h]: got %h expected %h", vin[i], out_q[i], vexp[i]);
            end
        end
    endtask

    task automatic test_backpressure;
        logic [31:0] vin[8] = '{32'h20000000, 32'hC0000001, 32'h00000100, 32'h7FFFFF80,
                                32'h80000001, 32'h12345678, 32'hFFFFFFFF, 32'h0000FFFF};
        int          idx  = 0;
        int          cyc  = 0;
        bit          have = 1'b0;
        logic [31:0] held = 32'h0;
        out_q.delete();
        out_ready = 1'b0;
        for (int c = 0; c < 5; c++) begin
            in_valid = (idx < 8);
            in_data  = vin[idx];
            @(negedge clk);
            if (out_valid) begin
                if (have) begin
                    checks++;
                    if (out_data !== held) begin
                        errors++;
                        $display("FAIL stall_stable[cycle %0d]: got %h expected %h", c, out_data, held);
                    end
                end else begin
                    have = 1'b1;
                    held = out_data;
                    checks++;
                    if (out_data !== ref_conv(vin[0])) begin
                        errors++;
                        $display("FAIL stall_head: got %h expected %h", out_data, ref_conv(vin[0]));
                    end
                end
            end
            if (in_valid && in_ready) idx++;
            @(posedge clk); #1;
        end
        checks++;
        if (idx != 3) begin
            errors++;
            $display("FAIL stall_accepted: got %0d expected 3", idx);
        end
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL stall_in_ready: got %b expected 0", in_ready);
        end
        out_ready = 1'b1;
        while ((idx < 8 || out_q.size() < 8) && cyc < 100) begin
            in_valid = (idx < 8);
            in_data  = (idx < 8) ? vin[idx] : 32'h0;
            @(negedge clk);
            if (in_valid && in_ready) idx++;
            @(posedge clk); #1;
            cyc++;
        end
        in_valid = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
        end
        checks++;
        if (out_q.size() != 8) begin
            errors++;
            $display("FAIL bp_count: got %0d expected 8", out_q.size());
        end
        for (int i = 0; i < 8 && i < out_q.size(); i++) begin
            checks++;
            if (out_q[i] !== ref_conv(vin[i])) begin
                errors++;
                $display("FAIL bp_order[%0d]: got %h expected %h", i, out_q[i], ref_conv(vin[i]));
            end
        end
    endtask

    task automatic test_reset_midstream;
        logic [31:0] vin[3] = '{32'h20000000, 32'h40000000, 32'hE0000000};
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            in_data  = vin[i];
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1) begin
            errors++;
            $display("FAIL mid_pre_valid: got %b expected 1", out_valid);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL mid_rst_valid: got %b expected 0", out_valid);
        end
        checks++;
        if (out_data !== 32'h0) begin
            errors++;
            $display("FAIL mid_rst_data: got %h expected 00000000", out_data);
        end
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        out_q.delete();
        out_ready = 1'b1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL mid_in_ready: got %b expected 1", in_ready);
        end
        repeat (6) begin
            @(posedge clk); #1;
        end
        checks++;
        if (out_q.size() != 0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL mid_stale: got %0d outputs valid=%b expected 0 outputs valid=0", out_q.size(), out_valid);
        end
    endtask

    task automatic test_random;
        logic [31:0]        exp_q[$];
        logic signed [31:0] r;
        int                 sent = 0;
        int                 cyc  = 0;
        out_q.delete();
        while ((sent < 10000 || out_q.size() < sent) && cyc < 40000) begin
            r         = $signed($urandom);
            in_valid  = (sent < 10000) && ($urandom_range(3) != 0);
            in_data   = r >>> $urandom_range(31);
            out_ready = ($urandom_range(3) != 0);
            @(negedge clk);
            if (in_valid && in_ready) begin
                exp_q.push_back(ref_conv(in_data));
                sent++;
            end
            @(posedge clk); #1;
            cyc++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        checks++;
        if (out_q.size() != exp_q.size() || sent != 10000) begin
            errors++;
            $display("FAIL random_count: got %0d outputs for %0d inputs expected 10000 each", out_q.size(), sent);
        end
        for (int i = 0; i < exp_q.size() && i < out_q.size(); i++) begin
            checks++;
            if (out_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL random[%0d]: got %h expected %h", i, out_q[i], exp_q[i]);
            end
        end
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = 32'h0;
        out_ready = 1'b0;
        test_reset();
        test_basic();
        test_extremes();
        test_rounding();
        test_backpressure();
        test_reset_midstream();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
